rom_read_arbiter: RTL and testbench
===================================

# rom_read_arbiter

Round-robin arbiter that shares one synchronous-read 4x4 ROM among N_REQ requesters. Each requester raises a level request with an address; the arbiter issues one ROM read at a time, captures the returned word, and returns it with a one-cycle response pulse to the winning requester. The block sits between the lookup clients and the ROM, and is the only driver of the ROM enable and address.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 2, ROM address width
- DATA_W, 4, ROM data width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester read request, level, held until its rsp_valid bit is seen
- req_addr  input  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- rsp_valid  output  N_REQ  one-hot, one-cycle pulse: rsp_data is valid for that requester
- rsp_data  output  DATA_W  read data, held until the next capture
- rom_en  output  1  ROM read enable
- rom_addr  output  ADDR_W  ROM address
- rom_data  input  DATA_W  ROM registered output; valid the cycle after an enabled edge
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, pick a winner, latch owner index and its req_addr into rom_addr, go to ISSUE. Otherwise stay.
- ISSUE: rom_en=1 for exactly this cycle; go to WAIT.
- WAIT: rom_en=0; at the closing edge, latch rom_data into rsp_data and set rsp_valid[owner]; go to RESP.
- RESP: rsp_valid[owner]=1 for this cycle only; go to IDLE.
- Round-robin: search starts at last_grant+1 and wraps modulo N_REQ; last_grant updates to owner on each grant.
- The address is sampled only at the grant edge. Later changes to req_addr do not affect the current read.
- If req drops after grant, the transaction still completes and rsp_valid still pulses.
- Requests that arrive during ISSUE, WAIT or RESP wait in the req vector; they are never lost while held high.
- rom_addr holds its last value outside ISSUE.
- rom_en is never high in two consecutive cycles.
- Reset values: state=IDLE, rom_en=0, rom_addr=0, rsp_valid=0, rsp_data=0, busy=0, last_grant=N_REQ-1 (requester 0 wins first).
- Reset mid-transaction: everything clears immediately. The in-flight response is dropped and no rsp_valid is produced.

## Timing
- Request seen at edge E0 in IDLE → rom_en high in cycle E0–E1 → rom_data valid E1–E2 → rsp_valid high E2–E3 → IDLE E3–E4. Next arbitration is at E4.
- Latency is 3 cycles from the sampling edge to rsp_valid. Throughput is one read per 4 cycles.
- Requesters must clear req at the edge that ends their rsp_valid cycle. Otherwise a repeat read is issued.
- Arbitration, rsp_valid and rom_en are all registered. There is no combinational path from req to outputs.

## Configuration
- ROM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest-index asserted requester always wins, and last_grant is unused.
- Not defined (default): round-robin as described above.

## Test plan
- Reset, then a single request: assert req[2] with addr=3, ROM preset {0,5,10,15}.
  - rom_en pulses 1 cycle after sampling, with rom_addr=3.
  - rsp_valid=4'b0100 and rsp_data=15 arrive 3 cycles after sampling.
  - busy is high for 3 cycles.
- All four requesting continuously, addrs 0,1,2,3: grants go 0,1,2,3,0 and rsp_data reads 0,5,10,15,0, with one response every 4 cycles.
- Address changed after grant: req[1] with addr=1, changed to 2 the cycle after sampling → rsp_data=5.
- Reset asserted during WAIT:
  - rom_en, rsp_valid and busy go 0 immediately.
  - The cleared response never appears.
  - After release, a held request is re-served starting from requester 0 priority.
- req dropped during ISSUE: rsp_valid still pulses once for that requester. No second rom_en occurs without a new request.
- ROM_ARB_FIXED_PRIO_EN defined, req[0] and req[3] held continuously: requester 0 is granted every time and requester 3 is never granted.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Shares one synchronous-read ROM among N_REQ requesters. One read is in
// flight at a time: IDLE grants and latches the address, ISSUE pulses rom_en,
// WAIT captures the ROM word, RESP pulses rsp_valid for the owner.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   req[N_REQ]           level requests, held until the matching rsp_valid
//   req_addr             packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   rsp_valid[N_REQ]     one-hot single-cycle response strobe
//   rsp_data             last captured ROM word
//   rom_en, rom_addr     ROM read enable and address
//   rom_data             ROM registered output
//   busy                 high whenever the FSM is not IDLE
//
// Configuration macro: ROM_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest asserted index wins
//   undefined -> round-robin starting after the last grant
module rom_read_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  winner;
  logic [ADDR_W-1:0] win_addr;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest asserted index is the last write.
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Rotating search: first asserted requester after last_grant, wrapping.
  // When nothing is requested the result is ignored by the FSM.
  always_comb begin
    winner = last_grant;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  // Address mux for the winner, built from constant slices.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == winner) win_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // All outputs are registered here; the address is captured only at the
  // grant edge so later req_addr changes cannot disturb the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_grant <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= winner;
            rom_addr <= win_addr;
            rom_en   <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_grant <= winner;
`endif
          end
        end
        ISSUE: begin
          rom_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          rsp_data  <= rom_data;
          rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter
// Self-checking bench for rom_read_arbiter with a 4x4 ROM holding
// {0,5,10,15}. Expected responses (owner, data) are queued when requests are
// driven and popped by a monitor whenever rsp_valid pulses.
// Honours ROM_ARB_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_rom_read_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] req_addr;
  logic [3:0] rsp_valid;
  logic [3:0] rsp_data;
  logic       rom_en;
  logic [1:0] rom_addr;
  logic [3:0] rom_data;
  logic       busy;

  typedef struct packed {
    logic [1:0] who;
    logic [3:0] data;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  logic [3:0] rom_mem [4];

  rom_read_arbiter #(.N_REQ(4), .ADDR_W(2), .DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rom_mem[0] = 4'd0;
    rom_mem[1] = 4'd5;
    rom_mem[2] = 4'd10;
    rom_mem[3] = 4'd15;
  end

  // Synchronous-read ROM: data appears the cycle after an enabled edge.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard monitor; also flags rom_en high in two consecutive cycles.
  task automatic run_monitor();
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if (rom_en && prev_en) begin
          errors++;
          $display("[TB] FAIL rom_en_consecutive: got 1 twice, required single-cycle pulse");
        end
        prev_en = rom_en;
        if (rsp_valid != 4'b0) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_rsp: rsp_valid=%b data=%0d, required no response", rsp_valid, rsp_data);
          end else begin
            e = expq.pop_front();
            if (rsp_valid !== (4'b0001 << e.who) || rsp_data !== e.data) begin
              errors++;
              $display("[TB] FAIL scoreboard: rsp_valid=%b data=%0d, required %b data=%0d",
                       rsp_valid, rsp_data, 4'b0001 << e.who, e.data);
            end
          end
        end
      end else begin
        prev_en = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = 4'b0;
    req_addr = 8'b0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Requesters drop req at the edge ending their rsp_valid cycle.
  task automatic serve_all(input int max_cycles);
    int n;
    n = 0;
    while ((req != 4'b0 || busy) && n < max_cycles) begin
      @(negedge clk);
      req = req & ~rsp_valid;
      n++;
    end
    checks++;
    if (req != 4'b0 || busy) begin
      errors++;
      $display("[TB] FAIL serve_timeout: req=%b busy=%b after %0d cycles, required idle", req, busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 4'b0;
    req_addr = 8'b0;
    #1;
    checks++;
    if ({rom_en, rom_addr, rsp_valid, rsp_data, busy} !== 12'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: en=%b addr=%0d vld=%b data=%0d busy=%b, required all 0",
               rom_en, rom_addr, rsp_valid, rsp_data, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rom_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: busy=%b rom_en=%b, required 0 0", busy, rom_en);
    end
  endtask

  task automatic test_single();
    int busy_cnt;
    do_reset();
    req_addr[5:4] = 2'd3;
    req           = 4'b0100;
    expq.push_back('{who: 2'd2, data: 4'd15});
    busy_cnt = 0;
    @(negedge clk);
    busy_cnt += int'(busy);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 2'd3 || rsp_valid !== 4'b0) begin
      errors++;
      $display("[TB] FAIL single_issue: en=%b addr=%0d vld=%b, required 1 3 0000", rom_en, rom_addr, rsp_valid);
    end
    @(negedge clk);
    busy_cnt += int'(busy);
    checks++;
    if (rom_en !== 1'b0 || rsp_valid !== 4'b0) begin
      errors++;
      $display("[TB] FAIL single_wait: en=%b vld=%b, required 0 0000", rom_en, rsp_valid);
    end
    @(negedge clk);
    busy_cnt += int'(busy);
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 4'd15) begin
      errors++;
      $display("[TB] FAIL single_rsp: vld=%b data=%0d, required 0100 15", rsp_valid, rsp_data);
    end
    req = 4'b0;
    @(negedge clk);
    busy_cnt += int'(busy);
    checks++;
    if (rsp_valid !== 4'b0 || busy_cnt != 3) begin
      errors++;
      $display("[TB] FAIL single_busy: vld=%b busy_cycles=%0d, required 0000 3", rsp_valid, busy_cnt);
    end
  endtask

  task automatic test_round_robin();
    int cyc, last, cnt;
    do_reset();
    req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    req      = 4'b1111;
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) expq.push_back('{who: 2'd0, data: 4'd0});
`else
    expq.push_back('{who: 2'd0, data: 4'd0});
    expq.push_back('{who: 2'd1, data: 4'd5});
    expq.push_back('{who: 2'd2, data: 4'd10});
    expq.push_back('{who: 2'd3, data: 4'd15});
    expq.push_back('{who: 2'd0, data: 4'd0});
`endif
    cnt  = 0;
    last = 0;
    for (cyc = 0; cyc < 40 && cnt < 5; cyc++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) begin
        cnt++;
        if (cnt > 1) begin
          checks++;
          if (cyc - last != 4) begin
            errors++;
            $display("[TB] FAIL rr_spacing: gap=%0d cycles, required 4", cyc - last);
          end
        end
        last = cyc;
        if (cnt == 5) req = 4'b0;
      end
    end
    checks++;
    if (cnt != 5) begin
      errors++;
      $display("[TB] FAIL rr_count: responses=%0d, required 5", cnt);
    end
    serve_all(10);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_drain: pending=%0d, required 0", expq.size());
    end
  endtask

  task automatic test_addr_change();
    do_reset();
    req_addr[3:2] = 2'd1;
    req           = 4'b0010;
    expq.push_back('{who: 2'd1, data: 4'd5});
    @(negedge clk);
    req_addr[3:2] = 2'd2;
    checks++;
    if (rom_addr !== 2'd1) begin
      errors++;
      $display("[TB] FAIL addr_latch: rom_addr=%0d, required 1", rom_addr);
    end
    serve_all(12);
    checks++;
    if (expq.size() != 0 || rsp_data !== 4'd5) begin
      errors++;
      $display("[TB] FAIL addr_change: pending=%0d data=%0d, required 0 5", expq.size(), rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Move last_grant to requester 0 so the reset restore is observable.
    req = 4'b0001;
    expq.push_back('{who: 2'd0, data: 4'd0});
    serve_all(12);
    req_addr = {2'd0, 2'd2, 2'd1, 2'd0};
    req      = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rom_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_wait_state: busy=%b en=%b, required 1 0", busy, rom_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rom_en !== 1'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear: en=%b vld=%b busy=%b, required 0 0000 0", rom_en, rsp_valid, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expq.push_back('{who: 2'd1, data: 4'd5});
    expq.push_back('{who: 2'd2, data: 4'd10});
    @(negedge clk);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 2'd1) begin
      errors++;
      $display("[TB] FAIL mid_regrant: en=%b addr=%0d, required 1 1", rom_en, rom_addr);
    end
    serve_all(20);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_drain: pending=%0d, required 0", expq.size());
    end
  endtask

  task automatic test_req_drop();
    int en_cnt, rsp_cnt;
    do_reset();
    req_addr[7:6] = 2'd2;
    req           = 4'b1000;
    expq.push_back('{who: 2'd3, data: 4'd10});
    @(negedge clk);
    req     = 4'b0;
    en_cnt  = int'(rom_en);
    rsp_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      en_cnt += int'(rom_en);
      if (rsp_valid == 4'b1000) rsp_cnt++;
    end
    checks++;
    if (en_cnt != 1 || rsp_cnt != 1) begin
      errors++;
      $display("[TB] FAIL req_drop: rom_en_pulses=%0d rsp=%0d, required 1 1", en_cnt, rsp_cnt);
    end
  endtask

  task automatic test_pair_0_3();
    int cnt, n3;
    do_reset();
    req_addr = {2'd2, 2'd0, 2'd0, 2'd1};
    req      = 4'b1001;
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) expq.push_back('{who: 2'd0, data: 4'd5});
`else
    expq.push_back('{who: 2'd0, data: 4'd5});
    expq.push_back('{who: 2'd3, data: 4'd10});
    expq.push_back('{who: 2'd0, data: 4'd5});
`endif
    cnt = 0;
    n3  = 0;
    for (int c = 0; c < 30 && cnt < 3; c++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) cnt++;
      if (rsp_valid[3]) n3++;
      if (cnt == 3) req = 4'b0;
    end
    serve_all(10);
    checks++;
`ifdef ROM_ARB_FIXED_PRIO_EN
    if (cnt != 3 || n3 != 0 || expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL pair_fixed: rsp=%0d req3_grants=%0d pending=%0d, required 3 0 0", cnt, n3, expq.size());
    end
`else
    if (cnt != 3 || n3 != 1 || expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL pair_rr: rsp=%0d req3_grants=%0d pending=%0d, required 3 1 0", cnt, n3, expq.size());
    end
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0;
    req_addr = 8'b0;
    fork
      run_monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_addr_change();
    test_reset_mid();
    test_req_drop();
    test_pair_0_3();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_queue: pending=%0d, required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
